// File: rtl/csi_pkg.sv
// Shared constants and types for the CSI collector slice.
package csi_pkg;

    localparam int unsigned W_DEFAULT       = 20;
    localparam int unsigned WORDS_PER_FRAME = 6;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } csi_state_e;

    // Position of each word inside a frame.
    localparam logic [2:0] IDX_M1 = 3'd0;
    localparam logic [2:0] IDX_P1 = 3'd1;
    localparam logic [2:0] IDX_M2 = 3'd2;
    localparam logic [2:0] IDX_P2 = 3'd3;
    localparam logic [2:0] IDX_M3 = 3'd4;
    localparam logic [2:0] IDX_P3 = 3'(WORDS_PER_FRAME - 1);

endpackage

// File: rtl/csi_mag_acc.sv
// One signed magnitude accumulator with an AVG_LOG2-bit guard and a
// floor-averaged (arithmetic shift) read port.
module csi_mag_acc #(
    parameter int W        = 20,
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_add,
    input  logic                i_clr,
    input  logic signed [W-1:0] i_din,
    output logic signed [W-1:0] o_avg
);

    localparam int AW = W + AVG_LOG2;

    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_ext;

    assign w_ext = AW'(i_din);

    // Accumulate on add, zero on clear; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + w_ext;
        end
    end

    assign o_avg = W'(r_acc >>> AVG_LOG2);

endmodule

// File: rtl/csi_collector.sv
// Collects six-word CSI frames, averages magnitudes over 2^AVG_LOG2 frames,
// keeps the latest phases and publishes them with a two-cycle CSI_done strobe.
module csi_collector
    import csi_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int W        = W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] din,
    input  logic                din_valid,
    input  logic                din_sof,
    output logic signed [W-1:0] M1,
    output logic signed [W-1:0] P1,
    output logic signed [W-1:0] M2,
    output logic signed [W-1:0] P2,
    output logic signed [W-1:0] M3,
    output logic signed [W-1:0] P3,
    output logic                CSI_done,
    output logic                frame_err
);

    localparam logic [3:0]  AVG_N = 4'(1 << AVG_LOG2);
    localparam int unsigned BUF_D = WORDS_PER_FRAME - 1;

    csi_state_e          r_state, w_state_nx;
    logic [2:0]          r_idx, w_idx_nx, w_widx;
    logic [3:0]          r_fcnt, w_fcnt_nx;
    logic [1:0]          r_eph, w_eph_nx;
    logic                w_store, w_complete, w_load, w_ferr_nx, w_done_nx;
    logic                r_done, r_ferr;
    logic signed [W-1:0] r_word [BUF_D];
    logic signed [W-1:0] r_ph1, r_ph2, r_ph3;
    logic signed [W-1:0] r_m1, r_m2, r_m3, r_p1, r_p2, r_p3;
    logic signed [W-1:0] w_avg1, w_avg2, w_avg3;

    assign w_widx = din_sof ? IDX_M1 : r_idx;

    // Next-state, index, frame counter and datapath strobes.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_fcnt_nx  = r_fcnt;
        w_eph_nx   = r_eph;
        w_store    = 1'b0;
        w_complete = 1'b0;
        w_load     = 1'b0;
        w_ferr_nx  = 1'b0;
        w_done_nx  = r_done;
        case (r_state)
            IDLE: begin
                if (din_valid && din_sof) begin
                    w_store    = 1'b1;
                    w_idx_nx   = 3'd1;
                    w_state_nx = COLLECT;
                end
            end
            COLLECT: begin
                if (din_valid) begin
                    if (din_sof) begin
                        w_ferr_nx = 1'b1;
                        w_store   = 1'b1;
                        w_idx_nx  = 3'd1;
                    end else if (r_idx == IDX_P3) begin
                        w_complete = 1'b1;
                        w_idx_nx   = '0;
                        if (r_fcnt + 4'd1 == AVG_N) begin
                            w_fcnt_nx  = '0;
                            w_eph_nx   = '0;
                            w_state_nx = EMIT;
                        end else begin
                            w_fcnt_nx  = r_fcnt + 4'd1;
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_store  = 1'b1;
                        w_idx_nx = r_idx + 3'd1;
                    end
                end
            end
            EMIT: begin
                w_ferr_nx = din_valid && din_sof;
                // Phase 0 publishes and clears the accumulators one edge after
                // the final sum lands, so outputs lead the strobe by a cycle.
                case (r_eph)
                    2'd0: begin
                        w_load   = 1'b1;
                        w_eph_nx = 2'd1;
                    end
                    2'd1: begin
                        w_done_nx = 1'b1;
                        w_eph_nx  = 2'd2;
                    end
                    2'd2: begin
                        w_eph_nx = 2'd3;
                    end
                    default: begin
                        w_done_nx  = 1'b0;
                        w_eph_nx   = 2'd0;
                        w_state_nx = IDLE;
                    end
                endcase
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // FSM state and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_fcnt  <= '0;
            r_eph   <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_fcnt  <= w_fcnt_nx;
            r_eph   <= w_eph_nx;
            r_done  <= w_done_nx;
            r_ferr  <= w_ferr_nx;
        end
    end

    // Buffer words 0..4 of the frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BUF_D; i++) begin
                r_word[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < BUF_D; i++) begin
                if (w_store && (w_widx == 3'(i))) begin
                    r_word[i] <= din;
                end
            end
        end
    end

    // Latest phases, overwritten when a frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph1 <= '0;
            r_ph2 <= '0;
            r_ph3 <= '0;
        end else if (w_complete) begin
            r_ph1 <= r_word[IDX_P1];
            r_ph2 <= r_word[IDX_P2];
            r_ph3 <= din;
        end
    end

    // Published result registers, updated only in the first EMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m1 <= '0;
            r_m2 <= '0;
            r_m3 <= '0;
            r_p1 <= '0;
            r_p2 <= '0;
            r_p3 <= '0;
        end else if (w_load) begin
            r_m1 <= w_avg1;
            r_m2 <= w_avg2;
            r_m3 <= w_avg3;
            r_p1 <= r_ph1;
            r_p2 <= r_ph2;
            r_p3 <= r_ph3;
        end
    end

    csi_mag_acc #(.W(W), .AVG_LOG2(AVG_LOG2)) u_acc1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_add (w_complete),
        .i_clr (w_load),
        .i_din (r_word[IDX_M1]),
        .o_avg (w_avg1)
    );

    csi_mag_acc #(.W(W), .AVG_LOG2(AVG_LOG2)) u_acc2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_add (w_complete),
        .i_clr (w_load),
        .i_din (r_word[IDX_M2]),
        .o_avg (w_avg2)
    );

    csi_mag_acc #(.W(W), .AVG_LOG2(AVG_LOG2)) u_acc3 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_add (w_complete),
        .i_clr (w_load),
        .i_din (r_word[IDX_M3]),
        .o_avg (w_avg3)
    );

    assign M1        = r_m1;
    assign M2        = r_m2;
    assign M3        = r_m3;
    assign P1        = r_p1;
    assign P2        = r_p2;
    assign P3        = r_p3;
    assign CSI_done  = r_done;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_csi_collector.sv
// Self-checking bench for csi_collector: directed and randomized frames
// compared against a sum/floor-average reference model.
module tb_csi_collector;

    localparam int W        = 20;
    localparam int AVG_LOG2 = 2;
    localparam int AVG_N    = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic signed [W-1:0] din;
    logic                din_valid;
    logic                din_sof;
    logic signed [W-1:0] M1, P1, M2, P2, M3, P3;
    logic                CSI_done;
    logic                frame_err;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: running magnitude sums and latest phases.
    int m_sum [3];
    int m_ph  [3];

    always #5 clk = ~clk;

    csi_collector #(.AVG_LOG2(AVG_LOG2), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_sof   (din_sof),
        .M1        (M1),
        .P1        (P1),
        .M2        (M2),
        .P2        (P2),
        .M3        (M3),
        .P3        (P3),
        .CSI_done  (CSI_done),
        .frame_err (frame_err)
    );

    function automatic int floor_div(int s, int d);
        int q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int rnd_word();
        return int'($urandom_range(32'd1048575, 32'd0)) - 524288;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_sum[i] = 0;
            m_ph[i]  = 0;
        end
    endtask

    task automatic send_word(input int v, input bit sof, input int unsigned gmax);
        int unsigned g;
        g = $urandom_range(gmax, 0);
        repeat (g) @(posedge clk);
        #1;
        din       = W'(v);
        din_sof   = sof;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    // Sends one complete frame; optionally expects its sof to flag an error.
    task automatic send_frame(input int f [6], input int unsigned gmax, input bit expect_err);
        send_word(f[0], 1'b1, gmax);
        if (expect_err) begin
            @(negedge clk);
            chk("err.pulse", frame_err, 1);
            @(negedge clk);
            chk("err.one_cycle", frame_err, 0);
        end
        for (int k = 1; k < 6; k++) send_word(f[k], 1'b0, gmax);
        for (int i = 0; i < 3; i++) begin
            m_sum[i] += f[2*i];
            m_ph[i]   = f[2*i+1];
        end
    endtask

    task automatic rand_frame(input int unsigned gmax);
        int f [6];
        for (int k = 0; k < 6; k++) f[k] = rnd_word();
        send_frame(f, gmax, 1'b0);
    endtask

    // Called right after the final P3 is captured; steps the EMIT window.
    task automatic check_emit(input string tag, input bit sof_in_emit, input bit rst_in_e1);
        int em [3];
        int ep [3];
        for (int i = 0; i < 3; i++) begin
            em[i] = floor_div(m_sum[i], AVG_N);
            ep[i] = m_ph[i];
        end
        @(negedge clk);
        chk({tag, ".done_cyc1"}, CSI_done, 0);
        @(negedge clk);
        chk({tag, ".done_e0"}, CSI_done, 0);
        chk({tag, ".M1"}, M1, em[0]);
        chk({tag, ".M2"}, M2, em[1]);
        chk({tag, ".M3"}, M3, em[2]);
        chk({tag, ".P1"}, P1, ep[0]);
        chk({tag, ".P2"}, P2, ep[1]);
        chk({tag, ".P3"}, P3, ep[2]);
        if (sof_in_emit) begin
            din       = W'(rnd_word());
            din_sof   = 1'b1;
            din_valid = 1'b1;
        end
        @(negedge clk);
        chk({tag, ".done_e1"}, CSI_done, 1);
        chk({tag, ".M1_hold"}, M1, em[0]);
        if (sof_in_emit) begin
            chk({tag, ".emit_sof_err"}, frame_err, 1);
            din_valid = 1'b0;
            din_sof   = 1'b0;
        end
        if (rst_in_e1) begin
            rst_n = 1'b0;
            #1;
            chk({tag, ".rst_done"}, CSI_done, 0);
            chk({tag, ".rst_M1"}, M1, 0);
            chk({tag, ".rst_M2"}, M2, 0);
            chk({tag, ".rst_M3"}, M3, 0);
            chk({tag, ".rst_P1"}, P1, 0);
            chk({tag, ".rst_P2"}, P2, 0);
            chk({tag, ".rst_P3"}, P3, 0);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            chk({tag, ".done_e2"}, CSI_done, 1);
            chk({tag, ".P3_hold"}, P3, ep[2]);
            @(negedge clk);
            chk({tag, ".done_end"}, CSI_done, 0);
            chk({tag, ".err_end"}, frame_err, 0);
        end
        model_clear();
    endtask

    initial begin
        int fa [4][6];
        int f  [6];

        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        model_clear();

        repeat (3) @(negedge clk);
        chk("rst.done", CSI_done, 0);
        chk("rst.err", frame_err, 0);
        chk("rst.M1", M1, 0);
        chk("rst.P1", P1, 0);
        chk("rst.M2", M2, 0);
        chk("rst.P3", P3, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-sof words while idle are ignored.
        send_word(12345, 1'b0, 0);
        send_word(-777, 1'b0, 2);
        @(negedge clk);
        chk("idle_drop.err", frame_err, 0);

        // Directed set: M1 100,104,96,100; P1 -5,7,9,11; M2 -3,-2,-2,-2.
        fa[0] = '{100, -5, -3, rnd_word(), rnd_word(), rnd_word()};
        fa[1] = '{104,  7, -2, rnd_word(), rnd_word(), rnd_word()};
        fa[2] = '{ 96,  9, -2, rnd_word(), rnd_word(), rnd_word()};
        fa[3] = '{100, 11, -2, rnd_word(), rnd_word(), rnd_word()};
        for (int n = 0; n < 3; n++) send_frame(fa[n], 0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("A.no_early_done", CSI_done, 0);
        end
        send_frame(fa[3], 0, 1'b0);
        chk("A.model_M1", floor_div(m_sum[0], AVG_N), 100);
        chk("A.model_M2", floor_div(m_sum[1], AVG_N), -3);
        check_emit("A", 1'b0, 1'b0);

        // Same data with random valid gaps, plus a sof during EMIT.
        for (int n = 0; n < 4; n++) send_frame(fa[n], 7, 1'b0);
        check_emit("B", 1'b1, 1'b0);

        // Partial frame cut by a sof at index 3; large values must not leak.
        send_word(500000, 1'b1, 3);
        send_word(-400000, 1'b0, 3);
        send_word(500001, 1'b0, 3);
        for (int k = 0; k < 6; k++) f[k] = rnd_word();
        send_frame(f, 3, 1'b1);
        for (int n = 0; n < 3; n++) rand_frame(5);
        check_emit("C", 1'b0, 1'b0);

        // Reset during the strobe, then a fresh averaging set.
        for (int n = 0; n < 4; n++) rand_frame(7);
        check_emit("D", 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) rand_frame(7);
        check_emit("E", 1'b0, 1'b0);

        // Full-scale positive and negative magnitudes.
        for (int n = 0; n < 4; n++) begin
            f = '{524287, rnd_word(), 524287, rnd_word(), 524287, rnd_word()};
            send_frame(f, 0, 1'b0);
        end
        check_emit("FSpos", 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            f = '{-524288, rnd_word(), -524288, rnd_word(), -524288, rnd_word()};
            send_frame(f, 1, 1'b0);
        end
        check_emit("FSneg", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
